// File: rtl/adc_spi_responder_if.sv
// SPI pin and sample-source signals of the ADC responder.
// The DUT side uses the slave modport; the SPI master / sample source side uses master.
interface adc_spi_responder_if #(
    parameter int unsigned RES_W = 12,
    parameter int unsigned CH_W  = 3
);
    logic             SS_n;
    logic             SCLK;
    logic             MOSI;
    logic             MISO;
    logic             smpl_req;
    logic [CH_W-1:0]  chnnl_req;
    logic [RES_W-1:0] smpl;
    logic             smpl_vld;
    logic             frm_done;

    modport slave (
        input  SS_n, SCLK, MOSI, smpl, smpl_vld,
        output MISO, smpl_req, chnnl_req, frm_done
    );

    modport master (
        output SS_n, SCLK, MOSI, smpl, smpl_vld,
        input  MISO, smpl_req, chnnl_req, frm_done
    );
endinterface

// File: rtl/adc_spi_responder.sv
// SPI responder for an ADC128S-style 16-bit protocol: decodes the channel of each frame,
// requests a sample from a local source and returns it on MISO during the next frame.
module adc_spi_responder #(
    parameter int unsigned FRM_BITS = 16,
    parameter int unsigned RES_W    = 12,
    parameter int unsigned CH_W     = 3,
    parameter int unsigned CH_LSB   = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_spi_responder_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(FRM_BITS + 1);
    localparam int unsigned PAD_W = FRM_BITS - RES_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_REQ   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Synchronisers: [0] first flop, [1] synced value, [2] edge-detect history
    logic [2:0]          ss_sync;
    logic [2:0]          sclk_sync;
    logic [1:0]          mosi_sync;
    logic [1:0]          live;
    logic                armed;

    logic                ss_fall;
    logic                ss_rise;
    logic                sclk_rise;
    logic                sclk_fall;

    logic [FRM_BITS-1:0] rx_shft;
    logic [CNT_W-1:0]    bit_cnt;
    logic                frm_full;

    state_t              state, state_d;
    logic [RES_W-1:0]    result, result_d;
    logic [FRM_BITS-1:0] tx_shft, tx_d;
    logic [CH_W-1:0]     chnnl_q, chnnl_d;
    logic                req_q, req_d;
    logic                done_q, done_d;
    logic                miso_q, miso_d;

    // Pin synchronisers; armed stays low until SS_n has been seen high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
            live      <= 2'b00;
            armed     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[1:0], bus.SS_n};
            sclk_sync <= {sclk_sync[1:0], bus.SCLK};
            mosi_sync <= {mosi_sync[0], bus.MOSI};
            live      <= {live[0], 1'b1};
            armed     <= armed | (live[1] & ss_sync[1]);
        end
    end

    assign ss_fall   = armed & ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    assign frm_full  = (bit_cnt == CNT_W'(FRM_BITS));

    // Receive shifter and saturating bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shft <= '0;
            bit_cnt <= '0;
        end else begin
            if (sclk_rise) begin
                rx_shft <= {rx_shft[FRM_BITS-2:0], mosi_sync[1]};
            end
            if (ss_fall) begin
                bit_cnt <= '0;
            end else if (sclk_rise && !frm_full) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            result  <= '0;
            tx_shft <= '0;
            chnnl_q <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            state   <= state_d;
            result  <= result_d;
            tx_shft <= tx_d;
            chnnl_q <= chnnl_d;
            req_q   <= req_d;
            done_q  <= done_d;
            miso_q  <= miso_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d  = state;
        result_d = result;
        tx_d     = tx_shft;
        chnnl_d  = chnnl_q;
        req_d    = 1'b0;
        done_d   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    tx_d    = {PAD_W'(0), result};
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A fall before the first rise only sets up bit 15, which is already on MISO
                if (sclk_fall && (bit_cnt != '0)) begin
                    tx_d = {tx_shft[FRM_BITS-2:0], 1'b0};
                end
                if (ss_rise) begin
                    if (frm_full) begin
                        chnnl_d = rx_shft[CH_LSB +: CH_W];
                        done_d  = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REQ: begin
                req_d = 1'b1;
                if (ss_fall) begin
                    tx_d    = {PAD_W'(0), result};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.smpl_vld) begin
                    result_d = bus.smpl;
                end
                // A new frame abandons the request; a coincident sample still wins
                if (ss_fall) begin
                    tx_d    = {PAD_W'(0), (bus.smpl_vld ? bus.smpl : result)};
                    state_d = ST_SHIFT;
                end else if (bus.smpl_vld) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        miso_d = ~ss_sync[1] & tx_d[FRM_BITS-1];
    end

    assign bus.MISO      = miso_q;
    assign bus.smpl_req  = req_q;
    assign bus.chnnl_req = chnnl_q;
    assign bus.frm_done  = done_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: an SPI master task, a sample-source model,
// and a monitor that checks frm_done/smpl_req/MISO words against queued expectations.
module tb_adc_spi_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   ss_rise_cyc = 0;
    int   inject_at = -1;
    bit   withhold = 1'b0;

    logic [11:0] src_val [8];

    logic [2:0]  exp_frm_q [$];
    logic [2:0]  exp_req_q [$];
    logic [31:0] exp_word_q [$];
    logic [31:0] got_word_q [$];

    adc_spi_responder_if #(.RES_W(12), .CH_W(3)) bus ();

    adc_spi_responder #(
        .FRM_BITS(16), .RES_W(12), .CH_W(3), .CH_LSB(11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame: SCLK idles high, MOSI changes on fall, MISO sampled at rise
    task automatic spi_frame(input logic [31:0] word, input int nbits);
        logic [31:0] w;
        w = '0;
        bus.SS_n = 1'b0;
        bus.MOSI = word[nbits-1];
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = word[nbits-1-i];
            wait_clk(8);
            w = {w[30:0], bus.MISO};
            bus.SCLK = 1'b1;
            wait_clk(8);
        end
        bus.SS_n = 1'b1;
        ss_rise_cyc = cyc;
        got_word_q.push_back(w);
        wait_clk(14);
    endtask

    task automatic full_frame(input logic [2:0] ch, input logic [11:0] exp_res);
        exp_frm_q.push_back(ch);
        exp_req_q.push_back(ch);
        exp_word_q.push_back({20'h0, exp_res});
        spi_frame({16'h0, 2'b00, ch, 11'h000}, 16);
    endtask

    // Sample source: answers requests two clocks later unless withheld; can inject a stray strobe
    initial begin
        int ch;
        bus.smpl     = '0;
        bus.smpl_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == inject_at) begin
                bus.smpl     = 12'h555;
                bus.smpl_vld = 1'b1;
                @(negedge clk);
                bus.smpl_vld = 1'b0;
            end else if (bus.smpl_req === 1'b1 && !withhold) begin
                ch = int'(bus.chnnl_req);
                repeat (2) @(negedge clk);
                bus.smpl     = src_val[ch];
                bus.smpl_vld = 1'b1;
                @(negedge clk);
                bus.smpl_vld = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pulse or a frame completes
    initial begin
        int frm_cyc;
        logic [2:0] e;
        logic [31:0] ew;
        frm_cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.frm_done === 1'b1) begin
                frm_cyc = cyc;
                check("frm_done_latency", 32'(cyc - ss_rise_cyc), 32'd3);
                if (exp_frm_q.size() == 0) check("unexpected_frm_done", 32'd1, 32'd0);
                else begin
                    e = exp_frm_q.pop_front();
                    check("frm_done_chnnl", 32'(bus.chnnl_req), 32'(e));
                end
            end
            if (bus.smpl_req === 1'b1) begin
                check("smpl_req_latency", 32'(cyc - frm_cyc), 32'd1);
                if (exp_req_q.size() == 0) check("unexpected_smpl_req", 32'd1, 32'd0);
                else begin
                    e = exp_req_q.pop_front();
                    check("smpl_req_chnnl", 32'(bus.chnnl_req), 32'(e));
                end
            end
            if (got_word_q.size() != 0) begin
                if (exp_word_q.size() == 0) check("unexpected_miso_word", 32'd1, 32'd0);
                else begin
                    ew = exp_word_q.pop_front();
                    check("miso_word", got_word_q.pop_front(), ew);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < 8; c++) src_val[c] = 12'(c * 257);
        src_val[3] = 12'hABC;
        rst_n    = 1'b0;
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        wait_clk(5);
        check("reset_miso", 32'(bus.MISO), 32'd0);
        check("reset_smpl_req", 32'(bus.smpl_req), 32'd0);
        check("reset_frm_done", 32'(bus.frm_done), 32'd0);
        check("reset_chnnl_req", 32'(bus.chnnl_req), 32'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // First frame returns zero; request for ch3 answered with ABC
        exp_frm_q.push_back(3'd3);
        exp_req_q.push_back(3'd3);
        exp_word_q.push_back(32'h0000_0000);
        spi_frame(32'h0000_1800, 16);
        src_val[3] = 12'h303;

        // Back-to-back channels 0..7, each frame returns the previous request
        for (int c = 0; c < 8; c++) begin
            full_frame(3'(c), (c == 0) ? 12'hABC : 12'((c - 1) * 257));
        end

        // Short frame (9 rises): only the partial MISO word, no frame output
        exp_word_q.push_back(32'h0000_000E);
        spi_frame(32'h0000_1000, 9);

        // 18-rise frame: last 16 MOSI bits decode ch1, MISO tail shifts in zeros
        exp_frm_q.push_back(3'd1);
        exp_req_q.push_back(3'd1);
        exp_word_q.push_back(32'h0000_1C1C);
        spi_frame(32'h0003_0800, 18);

        // Withheld sample: new frames see the stale value, stray strobe mid-frame ignored
        withhold = 1'b1;
        full_frame(3'd6, 12'h101);
        inject_at = cyc + 40;
        full_frame(3'd2, 12'h101);
        withhold = 1'b0;
        full_frame(3'd4, 12'h101);

        // Reset in the middle of a frame at bit 7; rest of that frame must be ignored
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 16; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = 1'b1;
            wait_clk(8);
            bus.SCLK = 1'b1;
            wait_clk(4);
            if (i == 6) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("midreset_miso", 32'(bus.MISO), 32'd0);
                check("midreset_smpl_req", 32'(bus.smpl_req), 32'd0);
                check("midreset_frm_done", 32'(bus.frm_done), 32'd0);
                check("midreset_chnnl_req", 32'(bus.chnnl_req), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            wait_clk(4);
        end
        bus.SS_n = 1'b1;
        wait_clk(14);

        // Behaves as after power-up
        full_frame(3'd5, 12'h000);
        full_frame(3'd0, 12'h505);

        wait_clk(20);
        check("frm_queue_drained", 32'(exp_frm_q.size()), 32'd0);
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("word_queue_drained", 32'(exp_word_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
